// File: rtl/mux_pkg.sv
// Shared constants and select-width helper for the pipelined N-way selector.
package mux_pkg;

  localparam int MAX_NUM_IN = 16;
  localparam int MAX_STAGES = 4;

  // Select width is clog2(n), but never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way selector: out-of-range select values return all zeros.
module mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]          in_data_i,
  input  logic [sel_width(NUM_IN)-1:0]     sel_i,
  output logic [WIDTH-1:0]                 sel_val_o
);

  localparam int SEL_W   = sel_width(NUM_IN);
  localparam int ENTRIES = 2 ** SEL_W;

  logic [WIDTH-1:0] table_s [ENTRIES];

  // Pad the table to a full power of two so unused codes decode to zero.
  for (genvar k = 0; k < ENTRIES; k++) begin : g_ent
    if (k < NUM_IN) begin : g_in
      assign table_s[k] = in_data_i[k*WIDTH +: WIDTH];
    end else begin : g_zero
      assign table_s[k] = '0;
    end
  end

  assign sel_val_o = table_s[sel_i];

endmodule

// File: rtl/mux_pipe_reg.sv
// Selector followed by STAGES stall/flush-capable register stages.
// Optional macro SEL_ERR_EN adds a sticky out-of-range select flag (sel_err).
module mux_pipe_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int STAGES = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_IN*WIDTH-1:0]        in_data,
  input  logic [sel_width(NUM_IN)-1:0]   SEL,
  input  logic                           in_valid,
  input  logic                           stall,
  input  logic                           flush,
  output logic [WIDTH-1:0]               out,
  output logic                           out_valid
`ifdef SEL_ERR_EN
  ,
  output logic                           sel_err
`endif
);

  localparam int SEL_W = sel_width(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("mux_pipe_reg: NUM_IN out of range 2..16");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("mux_pipe_reg: STAGES out of range 1..4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("mux_pipe_reg: WIDTH must be positive");
  end

  logic [WIDTH-1:0]  sel_val_s;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data_i (in_data),
    .sel_i     (SEL),
    .sel_val_o (sel_val_s)
  );

  // Next-state of the stage registers: flush beats stall beats advance.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        data_d[i] = '0;
      end
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? sel_val_s : '0;
      // Bubbles already carry zero data, so downstream stages copy verbatim.
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out       = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];

`ifdef SEL_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  logic oor_s;
  logic sel_err_q, sel_err_d;

  assign oor_s = ({1'b0, SEL} >= NUM_IN_L);

  // Flag is only raised by a select that actually enters the pipe.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_valid && !stall && !flush && oor_s) begin
      sel_err_d = 1'b1;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: five instances (various STAGES / NUM_IN) share one stimulus stream.
module tb_mux_pipe_reg;

  localparam int W  = 8;
  localparam int NU = 5;
  localparam int ST [NU] = '{1, 2, 3, 4, 1};
  localparam int NI [NU] = '{4, 4, 4, 4, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        stall;
  logic        flush;

  logic [W-1:0] o [NU];
  logic         ov [NU];
  logic [8:0]   obs [NU];
  logic         se [NU];

  logic [8:0] sbq [NU][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .STAGES(1)) u0 (
    .CLK(clk), .RST(rst), .in_data(in_data), .SEL(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o[0]), .out_valid(ov[0])
`ifdef SEL_ERR_EN
    , .sel_err(se[0])
`endif
  );
  mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .STAGES(2)) u1 (
    .CLK(clk), .RST(rst), .in_data(in_data), .SEL(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o[1]), .out_valid(ov[1])
`ifdef SEL_ERR_EN
    , .sel_err(se[1])
`endif
  );
  mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .STAGES(3)) u2 (
    .CLK(clk), .RST(rst), .in_data(in_data), .SEL(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o[2]), .out_valid(ov[2])
`ifdef SEL_ERR_EN
    , .sel_err(se[2])
`endif
  );
  mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .STAGES(4)) u3 (
    .CLK(clk), .RST(rst), .in_data(in_data), .SEL(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o[3]), .out_valid(ov[3])
`ifdef SEL_ERR_EN
    , .sel_err(se[3])
`endif
  );
  mux_pipe_reg #(.WIDTH(W), .NUM_IN(3), .STAGES(1)) u4 (
    .CLK(clk), .RST(rst), .in_data(in_data[23:0]), .SEL(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o[4]), .out_valid(ov[4])
`ifdef SEL_ERR_EN
    , .sel_err(se[4])
`endif
  );

  for (genvar k = 0; k < NU; k++) begin : g_obs
    assign obs[k] = {ov[k], o[k]};
  end

  // Expected {valid, data} entering stage 1 for an instance with n inputs.
  function automatic logic [8:0] ref_entry(input int n, input logic v,
                                           input logic [1:0] s, input logic [31:0] d);
    int si;
    si = int'(s);
    if (!v) return 9'h000;
    if (si >= n) return 9'h100;
    return {1'b1, d[si*8 +: 8]};
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sb_clear();
    for (int k = 0; k < NU; k++) begin
      sbq[k].delete();
      for (int j = 0; j < ST[k]; j++) sbq[k].push_back(9'h000);
    end
  endtask

  // Drive one cycle, push the expected entry, then compare every instance.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic stl, input logic fl);
    @(negedge clk);
    rst = r; in_valid = v; sel = s; stall = stl; flush = fl;
    @(posedge clk);
    if (r || fl) begin
      sb_clear();
    end else if (!stl) begin
      for (int k = 0; k < NU; k++) begin
        sbq[k].push_back(ref_entry(NI[k], v, s, in_data));
        void'(sbq[k].pop_front());
      end
    end
    #1;
    for (int k = 0; k < NU; k++) begin
      chk($sformatf("sb_u%0d", k), obs[k], sbq[k][0]);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
`ifdef SEL_ERR_EN
    chk(tag, {8'h00, se[4]}, {8'h00, exp});
    chk({tag, "_inrange"}, {8'h00, se[0]}, 9'h000);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; stall = 1'b0; flush = 1'b0;
    in_data = 32'h4433_2211;
    sb_clear();

    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reset_u0", obs[0], 9'h000);
    chk("reset_u3", obs[3], 9'h000);
    chk_err("reset_sel_err", 1'b0);

    // SEL steps 0..3 on consecutive cycles
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("sel0_u0", obs[0], 9'h111);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("basic_sel2_u0", obs[0], 9'h133);
    chk("lat3_c3", obs[2], 9'h111);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("lat3_c4", obs[2], 9'h122);
    chk("oor_u4", obs[4], 9'h100);
    chk_err("oor_sel_err_set", 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("lat3_c5", obs[2], 9'h133);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("lat3_c6", obs[2], 9'h144);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("lat3_c7", obs[2], 9'h000);
    repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Stall holds A; SEL/in_valid during stall are ignored
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    chk("stall_pre_u1", obs[1], 9'h111);
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    chk("stall1_u1", obs[1], 9'h111);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    chk("stall2_u1", obs[1], 9'h111);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("stall_rel_u1", obs[1], 9'h122);
    repeat (4) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Flush together with stall empties every stage
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("preflush_u0", obs[0], 9'h144);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("flush_u%0d", k), obs[k], 9'h000);
    repeat (5) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("flush_no_old_u3", obs[3], 9'h000);
      chk("flush_no_old_u2", obs[2], 9'h000);
    end
    chk_err("sel_err_sticky", 1'b1);

    // Reset with three entries in flight in the 4-stage instance
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("midrst_u3", obs[3], 9'h000);
    chk_err("midrst_sel_err", 1'b0);
    repeat (4) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("midrst_drain_u3", obs[3], 9'h000);
    end

    // sel_err only set by an out-of-range select that advances
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    chk_err("sel_err_stalled", 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    chk_err("sel_err_flushed", 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("oor2_u4", obs[4], 9'h100);
    chk("inrange_sel3_u0", obs[0], 9'h144);
    chk_err("sel_err_set2", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_pipe_reg.md
MUX_PIPE_REG -- requirements
Module: mux_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width per input.
REQ-002 The block SHALL have parameter NUM_IN, default 4, meaning number of inputs; legal range 2..16.
REQ-003 The block SHALL have parameter STAGES, default 1, meaning register stages after the selector; legal range 1..4.
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit, the reset; synchronous, active-high.
REQ-006 The block SHALL have port in_data, input, NUM_IN*WIDTH bits, packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port SEL, input, SEL_W = max(1, clog2(NUM_IN)) bits, input index.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the selected value is to enter stage 1.
REQ-009 The block SHALL have port stall, input, 1 bit, meaning all stages hold.
REQ-010 The block SHALL have port flush, input, 1 bit, meaning all stages are cleared to a bubble.
REQ-011 The block SHALL have port out, output, WIDTH bits, the data of the last stage.
REQ-012 The block SHALL have port out_valid, output, 1 bit, the valid bit of the last stage.
REQ-013 The block SHALL have port sel_err, output, 1 bit, a sticky out-of-range select flag; present only with SEL_ERR_EN.

Function
REQ-014 The selector SHALL be combinational: sel_val = input[SEL] when SEL < NUM_IN, else all zeros.
REQ-015 Each stage SHALL hold {valid, data}; stage 1 loads {in_valid, sel_val}; stage i loads stage i-1.
REQ-016 Latency SHALL be exactly STAGES cycles from a sampled input to out/out_valid, in the absence of stall.
REQ-017 A stage whose loaded valid is 0 SHALL load data 0, so bubbles always carry zero data.
REQ-018 With stall=1 and flush=0, every stage SHALL hold its contents; in_valid and SEL are ignored that cycle.
REQ-019 With flush=1, every stage SHALL load {0, 0} on the next edge, regardless of stall or in_valid.
REQ-020 Priority SHALL be RST > flush > stall > normal advance.
REQ-021 out and out_valid SHALL be driven directly from last-stage registers, with no combinational path from inputs.
REQ-022 An out-of-range SEL with in_valid=1 SHALL still advance a valid entry carrying zero data.

Reset
REQ-023 On RST=1 at a rising edge, all stage valid and data registers SHALL become 0.
REQ-024 After reset, out and out_valid SHALL read 0 until the first valid value has traversed STAGES stages.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight entries; no entry SHALL emerge after reset.
REQ-026 With SEL_ERR_EN, sel_err SHALL reset to 0.

Configuration
REQ-027 Macro SEL_ERR_EN SHALL compile in the sel_err port and logic.
REQ-028 With SEL_ERR_EN, sel_err SHALL set on an edge where in_valid=1, stall=0, flush=0 and SEL >= NUM_IN.
REQ-029 With SEL_ERR_EN, sel_err SHALL stay set until RST.
REQ-030 Without SEL_ERR_EN, the sel_err port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package mux_pkg SHALL hold the SEL_W computation function and the MAX_NUM_IN=16 and MAX_STAGES=4 constants.
REQ-032 Combinational selection SHALL be a sub-module mux_n, parameterised by WIDTH and NUM_IN, instanced once.
REQ-033 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-034 The bench SHALL cover basic select: STAGES=1, NUM_IN=4, inputs 0x11,0x22,0x33,0x44, SEL=2, in_valid=1 -> next cycle out=0x33, out_valid=1.
REQ-035 The bench SHALL cover latency: STAGES=3, SEL stepping 0,1,2,3 on consecutive cycles -> out shows inputs 0,1,2,3 on cycles 3,4,5,6.
REQ-036 The bench SHALL cover stall: STAGES=2, stream A,B, then stall=1 for 2 cycles -> out holds A with out_valid=1; B appears one cycle after stall deasserts.
REQ-037 The bench SHALL cover flush over stall: stream in flight, stall=1 and flush=1 together -> next cycle out=0, out_valid=0, and no old entry ever appears.
REQ-038 The bench SHALL cover out-of-range: NUM_IN=3, SEL=3, in_valid=1 -> out=0, out_valid=1; with SEL_ERR_EN, sel_err=1 and it persists until RST.
REQ-039 The bench SHALL cover reset mid-stream: STAGES=4, 3 valid entries in flight, RST=1 for one cycle -> out_valid stays 0 for 4 cycles with in_valid=0.
